// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - issue-stage handshake bundle: upstream instr/operands in, decoded ALU slot out
interface alu_issue_stage_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  aluc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic        ovf_trap_en;
  logic        illegal;

  modport master (
    output flush, in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, aluc, alu_a, alu_b, wb_addr, wb_en, ovf_trap_en, illegal
  );

  modport slave (
    input  flush, in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, aluc, alu_a, alu_b, wb_addr, wb_en, ovf_trap_en, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - MIPS decode/issue stage: one registered ALU slot with valid/ready and flush
module alu_issue_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus,
  output logic [CNT_W-1:0] issue_cnt
);

  logic [5:0]  op, fn;
  logic [4:0]  rs_f, rt_f, rd_f;
  logic [31:0] imm_s, imm_z, shamt;
  logic [3:0]  dec_aluc;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_wb_addr;
  logic        dec_wb, dec_trap, dec_ill;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       aluc_q, aluc_d;
  logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic             wb_en_q, wb_en_d, ovf_trap_en_q, ovf_trap_en_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             in_ready, accept, consume;

  assign op    = bus.instr[31:26];
  assign rs_f  = bus.instr[25:21];
  assign rt_f  = bus.instr[20:16];
  assign rd_f  = bus.instr[15:11];
  assign fn    = bus.instr[5:0];
  assign imm_s = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign imm_z = {16'h0000, bus.instr[15:0]};
  assign shamt = {27'd0, bus.instr[10:6]};

  always_comb begin
    dec_aluc    = 4'b0000;
    dec_a       = bus.rs_data;
    dec_b       = 32'd0;
    dec_wb_addr = 5'd0;
    dec_wb      = 1'b0;
    dec_trap    = 1'b0;
    dec_ill     = 1'b0;
    case (op)
      6'b000000: begin
        dec_b       = bus.rt_data;
        dec_wb_addr = rd_f;
        dec_wb      = 1'b1;
        case (fn)
          6'b100000: begin dec_aluc = 4'b0010; dec_trap = 1'b1; end
          6'b100001: dec_aluc = 4'b0000;
          6'b100010: begin dec_aluc = 4'b0011; dec_trap = 1'b1; end
          6'b100011: dec_aluc = 4'b0001;
          6'b100100: dec_aluc = 4'b0100;
          6'b100101: dec_aluc = 4'b0101;
          6'b100110: dec_aluc = 4'b0110;
          6'b100111: dec_aluc = 4'b0111;
          6'b101010: dec_aluc = 4'b1011;
          6'b101011: dec_aluc = 4'b1010;
          6'b000000: begin dec_aluc = 4'b1110; dec_a = shamt; end
          6'b000010: begin dec_aluc = 4'b1101; dec_a = shamt; end
          6'b000011: begin dec_aluc = 4'b1100; dec_a = shamt; end
          6'b000100: dec_aluc = 4'b1110;
          6'b000110: dec_aluc = 4'b1101;
          6'b000111: dec_aluc = 4'b1100;
          default:   dec_ill = 1'b1;
        endcase
      end
      6'b011100: begin
        dec_aluc    = 4'b1001;
        dec_wb_addr = rd_f;
        dec_wb      = 1'b1;
        dec_ill     = (fn != 6'b100000);
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec_b       = imm_s;
        dec_wb_addr = rt_f;
        dec_wb      = 1'b1;
        case (op[2:0])
          3'b000: begin dec_aluc = 4'b0010; dec_trap = 1'b1; end
          3'b001: dec_aluc = 4'b0000;
          3'b010: dec_aluc = 4'b1011;
          3'b011: dec_aluc = 4'b1010;
          3'b100: begin dec_aluc = 4'b0100; dec_b = imm_z; end
          3'b101: begin dec_aluc = 4'b0101; dec_b = imm_z; end
          3'b110: begin dec_aluc = 4'b0110; dec_b = imm_z; end
          default: begin dec_aluc = 4'b1000; dec_a = 32'd0; end
        endcase
      end
      6'b100011, 6'b101011: begin
        dec_b       = imm_s;
        dec_wb_addr = rt_f;
      end
      6'b000100, 6'b000101: begin
        dec_aluc = 4'b0001;
        dec_b    = bus.rt_data;
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal encodings issue as an inert slot so execute can still raise the exception.
    if (dec_ill) begin
      dec_aluc    = 4'b0000;
      dec_a       = 32'd0;
      dec_b       = 32'd0;
      dec_wb_addr = 5'd0;
      dec_wb      = 1'b0;
      dec_trap    = 1'b0;
    end
    if (dec_wb_addr == 5'd0) dec_wb = 1'b0;
  end

  assign in_ready = (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  // A flushed slot that is also being taken this cycle still counts as issued.
  assign consume  = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    aluc_d        = aluc_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    wb_addr_d     = wb_addr_q;
    wb_en_d       = wb_en_q;
    ovf_trap_en_d = ovf_trap_en_q;
    illegal_d     = illegal_q;
    issue_cnt_d   = issue_cnt_q + {{(CNT_W-1){1'b0}}, consume};
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      aluc_d        = dec_aluc;
      alu_a_d       = dec_a;
      alu_b_d       = dec_b;
      wb_addr_d     = dec_wb_addr;
      wb_en_d       = dec_wb;
      ovf_trap_en_d = dec_trap;
      illegal_d     = dec_ill;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      aluc_q        <= 4'b0000;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      wb_addr_q     <= 5'd0;
      wb_en_q       <= 1'b0;
      ovf_trap_en_q <= 1'b0;
      illegal_q     <= 1'b0;
      issue_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      aluc_q        <= aluc_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      wb_addr_q     <= wb_addr_d;
      wb_en_q       <= wb_en_d;
      ovf_trap_en_q <= ovf_trap_en_d;
      illegal_q     <= illegal_d;
      issue_cnt_q   <= issue_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.aluc        = aluc_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.ovf_trap_en = ovf_trap_en_q;
  assign bus.illegal     = illegal_q;
  assign issue_cnt       = issue_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a table-driven decode model
`timescale 1ns/1ps
module tb_alu_issue_stage;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic        wb;
    logic        trap;
    logic        ill;
  } exp_t;

  // {funct, aluc, a_is_shamt, trap}
  localparam logic [11:0] R_TAB [16] = '{
    {6'b100000, 4'b0010, 2'b01}, {6'b100001, 4'b0000, 2'b00},
    {6'b100010, 4'b0011, 2'b01}, {6'b100011, 4'b0001, 2'b00},
    {6'b100100, 4'b0100, 2'b00}, {6'b100101, 4'b0101, 2'b00},
    {6'b100110, 4'b0110, 2'b00}, {6'b100111, 4'b0111, 2'b00},
    {6'b101010, 4'b1011, 2'b00}, {6'b101011, 4'b1010, 2'b00},
    {6'b000000, 4'b1110, 2'b10}, {6'b000010, 4'b1101, 2'b10},
    {6'b000011, 4'b1100, 2'b10}, {6'b000100, 4'b1110, 2'b00},
    {6'b000110, 4'b1101, 2'b00}, {6'b000111, 4'b1100, 2'b00}
  };
  // {opcode, aluc, zero_ext, trap, writes_back, a_is_zero}
  localparam logic [13:0] I_TAB [10] = '{
    {6'b001000, 4'b0010, 4'b0110}, {6'b001001, 4'b0000, 4'b0010},
    {6'b001100, 4'b0100, 4'b1010}, {6'b001101, 4'b0101, 4'b1010},
    {6'b001110, 4'b0110, 4'b1010}, {6'b001010, 4'b1011, 4'b0010},
    {6'b001011, 4'b1010, 4'b0010}, {6'b001111, 4'b1000, 4'b0011},
    {6'b100011, 4'b0000, 4'b0000}, {6'b101011, 4'b0000, 4'b0000}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if bus();
  logic [CNT_W-1:0] issue_cnt;

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst), .bus(bus), .issue_cnt(issue_cnt)
  );

  exp_t             exp_q[$];
  exp_t             pend, mon_e;
  bit               pend_v = 0;
  bit               mon_en = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [11:0] r;
    logic [13:0] it;
    logic [31:0] imm_s, imm_z;
    imm_s = {{16{ins[15]}}, ins[15:0]};
    imm_z = {16'h0000, ins[15:0]};
    e = '0;
    e.ill = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r = R_TAB[i];
      if (ins[31:26] == 6'd0 && ins[5:0] == r[11:6]) begin
        e = '{aluc: r[5:2], a: (r[1] ? {27'd0, ins[10:6]} : rs), b: rt,
              wa: ins[15:11], wb: 1'b1, trap: r[0], ill: 1'b0};
      end
    end
    for (int i = 0; i < 10; i++) begin
      it = I_TAB[i];
      if (ins[31:26] == it[13:8]) begin
        e = '{aluc: it[7:4], a: (it[0] ? 32'd0 : rs), b: (it[3] ? imm_z : imm_s),
              wa: ins[20:16], wb: it[1], trap: it[2], ill: 1'b0};
      end
    end
    if (ins[31:26] == 6'b000100 || ins[31:26] == 6'b000101)
      e = '{aluc: 4'b0001, a: rs, b: rt, wa: 5'd0, wb: 1'b0, trap: 1'b0, ill: 1'b0};
    if (ins[31:26] == 6'b011100 && ins[5:0] == 6'b100000)
      e = '{aluc: 4'b1001, a: rs, b: 32'd0, wa: ins[15:11], wb: 1'b1, trap: 1'b0, ill: 1'b0};
    if (e.wa == 5'd0) e.wb = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [11:0] r;
    logic [13:0] it;
    w = $urandom();
    case ($urandom_range(0, 9))
      0, 1, 2: begin r = R_TAB[$urandom_range(0, 15)]; w[31:26] = 6'd0; w[5:0] = r[11:6]; end
      3, 4, 5: begin it = I_TAB[$urandom_range(0, 9)]; w[31:26] = it[13:8]; end
      6:       w[31:26] = ($urandom_range(0, 1) != 0) ? 6'b000100 : 6'b000101;
      7:       begin w[31:26] = 6'b011100; if ($urandom_range(0, 1) != 0) w[5:0] = 6'b100000; end
      8:       w[31:26] = 6'd0;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
    if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
    return w;
  endfunction

  // One input cycle: drive, check in_ready against the occupancy model, predict the load.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                      input bit ordy, input bit fl, input bit ovr_en, input exp_t ovr);
    bit exp_rdy;
    @(posedge clk);
    #1;
    if (pend_v) begin exp_q.push_back(pend); pend_v = 0; end
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.rs_data   = rs;
    bus.rt_data   = rt;
    bus.out_ready = ordy;
    bus.flush     = fl;
    exp_rdy = (exp_q.size() == 0 || ordy) && !fl;
    #1;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    if (iv && exp_rdy) begin
      pend   = ovr_en ? ovr : model(ins, rs, rt);
      pend_v = 1;
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 32'd0, 32'd0, 32'd0, ordy, 1'b0, 1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_aluc"}, {28'd0, bus.aluc}, 32'd0);
    chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
    chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
    chk({tag, "_flags"}, {24'd0, bus.wb_addr, bus.wb_en, bus.ovf_trap_en, bus.illegal}, 32'd0);
    chk({tag, "_issue_cnt"}, {28'd0, issue_cnt}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
      chk("issue_cnt", {28'd0, issue_cnt}, {28'd0, exp_cnt});
      if (bus.out_valid && exp_q.size() != 0) begin
        mon_e = exp_q[0];
        chk("aluc", {28'd0, bus.aluc}, {28'd0, mon_e.aluc});
        chk("alu_a", bus.alu_a, mon_e.a);
        chk("alu_b", bus.alu_b, mon_e.b);
        chk("wb_addr", {27'd0, bus.wb_addr}, {27'd0, mon_e.wa});
        chk("ctl", {29'd0, bus.wb_en, bus.ovf_trap_en, bus.illegal},
            {29'd0, mon_e.wb, mon_e.trap, mon_e.ill});
      end
      if (exp_q.size() != 0 && bus.out_ready) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end else if (exp_q.size() != 0 && bus.flush) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.in_valid = 0; bus.instr = 0; bus.rs_data = 0; bus.rt_data = 0;
    bus.out_ready = 0; bus.flush = 0;
    #2;
    check_zero("reset");
    #10 rst = 1'b0;
    mon_en = 1;

    // Directed decodes with hand-derived expectations, streamed with out_ready high.
    step(1, 32'h2109FFFF, 32'd5, 32'd0, 1, 0, 1, '{4'b0010, 32'd5, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b1, 1'b0});
    step(1, 32'h35098000, 32'h11, 32'd0, 1, 0, 1, '{4'b0101, 32'h11, 32'h00008000, 5'd9, 1'b1, 1'b0, 1'b0});
    step(1, 32'h00095100, 32'h99, 32'd3, 1, 0, 1, '{4'b1110, 32'd4, 32'd3, 5'd10, 1'b1, 1'b0, 1'b0});
    step(1, 32'h01095007, 32'h77, 32'h88, 1, 0, 1, '{4'b1100, 32'h77, 32'h88, 5'd10, 1'b1, 1'b0, 1'b0});
    step(1, 32'h3C081234, 32'h55, 32'd0, 1, 0, 1, '{4'b1000, 32'd0, 32'h00001234, 5'd8, 1'b1, 1'b0, 1'b0});
    step(1, 32'hFC000000, 32'h1, 32'h2, 1, 0, 1, '{4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1});
    step(1, 32'h00220021, 32'h1, 32'h2, 1, 0, 1, '{4'b0000, 32'h1, 32'h2, 5'd0, 1'b0, 1'b0, 1'b0});
    step(1, 32'h012A5822, 32'h10, 32'h3, 1, 0, 1, '{4'b0011, 32'h10, 32'h3, 5'd11, 1'b1, 1'b1, 1'b0});
    idle(1);
    idle(1);

    // Stall three cycles with new input pending, then release.
    step(1, 32'h01095821, 32'h4, 32'h6, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 32'h01095823, 32'h9, 32'h2, 0, 0, 0, '0);
    step(1, 32'h01095823, 32'h9, 32'h2, 1, 0, 0, '0);
    idle(1);
    idle(1);

    // Flush a stalled slot while new input is offered.
    step(1, 32'h01095824, 32'h3, 32'h5, 0, 0, 0, '0);
    step(1, 32'h01095825, 32'h3, 32'h5, 0, 0, 0, '0);
    step(1, 32'h01095826, 32'h3, 32'h5, 0, 1, 0, '0);
    idle(0);
    idle(1);

    // Reset mid-operation: loaded and stalled slot.
    step(1, 32'h2109FFFF, 32'd7, 32'd0, 0, 0, 0, '0);
    idle(0);
    #1 rst = 1'b1;
    exp_q.delete();
    pend_v  = 0;
    exp_cnt = '0;
    #0.5;
    check_zero("midreset");
    #0.5 rst = 1'b0;
    #0.5;
    chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // Randomized traffic; the narrow counter wraps many times.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom(), $urandom(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 0, '0);
    end
    for (int i = 0; i < 4; i++) idle(1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that drives the ALU operand and control interface: aluc, operand a, operand b.
- Accepts one MIPS instruction word per handshake, together with register-file read data.
- Decodes the ALU operation, operand sources and writeback target, then registers them into a single output slot with valid/ready flow control.
- Sits between the register-file read and the ALU in the 54-instruction CPU.

Parameters:
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous kill of the held slot (branch/exception redirect).
- in_valid  in  1  instr/rs_data/rt_data are valid.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  instruction word.
- rs_data  in  32  GPR[rs].
- rt_data  in  32  GPR[rt].
- out_valid  out  1  issue slot holds a decoded op.
- out_ready  in  1  ALU/execute consumes the slot this cycle.
- aluc  out  4  ALU operation code.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- wb_addr  out  5  destination register.
- wb_en  out  1  result must be written back.
- ovf_trap_en  out  1  signed op; execute traps on the ALU overflow flag.
- illegal  out  1  opcode/funct not supported.
- issue_cnt  out  CNT_W  instructions issued (handshakes on the output side).

Behaviour:
- Reset: out_valid, aluc, alu_a, alu_b, wb_addr, wb_en, ovf_trap_en, illegal and issue_cnt are all 0.
- in_ready = (!out_valid | out_ready) & !flush. This is combinational.
- Load: when in_valid & in_ready, decoded fields register on the next edge and out_valid becomes 1. Latency is 1 cycle.
- Hold: when out_valid & !out_ready & !flush, every output is held stable.
- Drain: when out_valid & out_ready & !(in_valid & in_ready), out_valid goes to 0.
- Back-to-back: consume and load in the same cycle sustain one instruction per cycle.
- Flush has priority. Next cycle out_valid=0 and no input is accepted that cycle.
- Flush with out_ready high in the same cycle: the held slot counts as consumed.
- issue_cnt increments on each out_valid & out_ready and wraps modulo 2^CNT_W.
- Immediates: andi, ori and xori zero-extend imm16. All other immediate instructions sign-extend imm16.
- shamt = instr[10:6], zero-extended to 32 bits.
- R-type (op 000000), funct -> aluc, a, b:
  - 100000 add -> 0010, rs, rt, ovf_trap_en=1.
  - 100001 addu -> 0000.
  - 100010 sub -> 0011, ovf_trap_en=1.
  - 100011 subu -> 0001.
  - 100100 and -> 0100.
  - 100101 or -> 0101.
  - 100110 xor -> 0110.
  - 100111 nor -> 0111.
  - 101010 slt -> 1011.
  - 101011 sltu -> 1010.
  - 000000 sll -> 1110, a=shamt, b=rt.
  - 000010 srl -> 1101, a=shamt.
  - 000011 sra -> 1100, a=shamt.
  - 000100 sllv -> 1110, a=rs.
  - 000110 srlv -> 1101, a=rs.
  - 000111 srav -> 1100, a=rs.
  - R-type: wb_addr=rd.
- SPECIAL2 (op 011100) funct 100000 clz -> 1001, a=rs, b=0, wb_addr=rd.
- I-type, b=imm, a=rs, wb_addr=rt:
  - 001000 addi -> 0010, ovf_trap_en=1.
  - 001001 addiu -> 0000.
  - 001100 andi -> 0100.
  - 001101 ori -> 0101.
  - 001110 xori -> 0110.
  - 001010 slti -> 1011.
  - 001011 sltiu -> 1010.
  - 001111 lui -> 1000, a=0.
- Memory address, no ALU writeback (wb_en=0):
  - 100011 lw -> 0000, a=rs, b=sext imm.
  - 101011 sw -> 0000, a=rs, b=sext imm.
- Branch compare, wb_en=0:
  - 000100 beq -> 0001, a=rs, b=rt.
  - 000101 bne -> 0001, a=rs, b=rt.
- wb_en = 1 for ALU-result instructions, except when wb_addr == 0 (writes to $zero suppressed).
- Any other encoding:
  - illegal=1, aluc=0000, a=b=0, wb_en=0, ovf_trap_en=0.
  - out_valid is still asserted so execute can raise the exception.

Test Plan:
- Reset mid-operation: slot loaded and stalled; assert reset for 1 ns between edges -> all outputs 0 immediately; in_ready=1 after release.
- addi $t1,$t0,-1 (0x2109FFFF), rs_data=5 -> next cycle aluc=0010, a=5, b=0xFFFFFFFF, wb_addr=9, wb_en=1, ovf_trap_en=1. ori $t1,$t0,0x8000 -> b=0x00008000, aluc=0101.
- sll $t2,$t1,4 (0x00095100), rt_data=0x3 -> aluc=1110, a=4, b=3, wb_addr=10. srav (0x01095007) -> aluc=1100, a=rs_data. lui $t0,0x1234 -> aluc=1000, b=0x00001234.
- Stall: load addu, hold out_ready=0 for 3 cycles with new in_valid -> outputs stable, in_ready=0. Release -> next op issues the following cycle; issue_cnt=1 then 2.
- Flush while a stalled slot is valid and in_valid=1 -> out_valid=0 next cycle, input not accepted, issue_cnt unchanged.
- Opcode 0x3F -> illegal=1, wb_en=0, out_valid=1. addu $0,$1,$2 -> wb_en=0.
- Streaming: 8 instructions with out_ready=1 -> one issue per cycle. Preload issue_cnt to 0xFFFFFFFF, then one issue -> issue_cnt wraps to 0.
